fa_bist: RTL and testbench

- Built-in self-test engine for the team's 1-bit full_adder.
- Generates the 8 exhaustive {a,b,cin} vectors in the same order the directed bench uses (000..111).
- Drives the vectors into an instantiated adder, samples cout/sum after a settle window, and compares them against a golden model.
- Reports pass/fail, error count and the first failing vector. It sits beside the adder as the response-checking end of the stimulus/response pair.

---
 rtl/fa_pkg.sv | 23 ++
 rtl/fa_golden.sv | 16 +
 rtl/fa_bist.sv | 177 +++++++++++++++++
 tb/tb_fa_bist.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Types, constants and golden full-adder functions shared by the full-adder
// BIST engine and its bench.
package fa_pkg;

    localparam int unsigned NUM_VECTORS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    function automatic logic fa_cout(input logic a, input logic b, input logic cin);
        return (a & b) | (a & cin) | (b & cin);
    endfunction

endpackage

// File: rtl/fa_golden.sv
// Combinational reference full adder that the BIST compares the device
// under test against.
module fa_golden
    import fa_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = fa_sum(a, b, cin);
    assign cout = fa_cout(a, b, cin);

endmodule

// File: rtl/fa_bist.sv
// Exhaustive self-test sequencer for a 1-bit full adder: applies the eight
// {a,b,cin} vectors, waits a settle window, then checks the response.
module fa_bist
    import fa_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       cin,
    input  logic       dut_cout,
    input  logic       dut_sum,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);

    localparam logic [3:0] SETTLE_L    = 4'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_PASS_L = 4'(PASSES - 1);
    localparam logic [2:0] LAST_IDX_L  = 3'(NUM_VECTORS - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] pass_cnt_q, pass_cnt_d;
    logic [2:0] stim_q, stim_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_q, err_d;
    logic       fail_valid_q, fail_valid_d;
    logic [2:0] fail_vec_q, fail_vec_d;
    logic       gold_sum_s;
    logic       gold_cout_s;
    logic       mismatch_s;

    fa_golden u_golden (
        .a    (stim_q[2]),
        .b    (stim_q[1]),
        .cin  (stim_q[0]),
        .sum  (gold_sum_s),
        .cout (gold_cout_s)
    );

    assign mismatch_s = (dut_sum != gold_sum_s) || (dut_cout != gold_cout_s);

    // Next-state and result bookkeeping for the run sequencer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        pass_cnt_d   = pass_cnt_q;
        stim_d       = stim_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = APPLY;
                    idx_d        = 3'd0;
                    pass_cnt_d   = 4'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_d        = 4'd0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = 3'd0;
                end else begin
                    // done/pass follow DONE by one cycle, giving the documented start-to-done latency
                    done_d = (state_q == DONE);
                    pass_d = (state_q == DONE) && (err_q == 4'd0);
                end
            end
            APPLY: begin
                stim_d = idx_q;
                busy_d = 1'b1;
                if (SETTLE_L == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_L;
                end
            end
            SETTLE: begin
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) begin
                    state_d = CHECK;
                end else begin
                    state_d = SETTLE;
                end
            end
            CHECK: begin
                if (mismatch_s) begin
                    if (err_q != 4'd15) begin
                        err_d = err_q + 4'd1;
                    end else begin
                        err_d = err_q;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = idx_q;
                    end else begin
                        fail_vec_d   = fail_vec_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (idx_q != LAST_IDX_L) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = APPLY;
                end else if (pass_cnt_q != LAST_PASS_L) begin
                    idx_d      = 3'd0;
                    pass_cnt_d = pass_cnt_q + 4'd1;
                    state_d    = APPLY;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            settle_q     <= 4'd0;
            pass_cnt_q   <= 4'd0;
            stim_q       <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 4'd0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            pass_cnt_q   <= pass_cnt_d;
            stim_q       <= stim_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign a          = stim_q[2];
    assign b          = stim_q[1];
    assign cin        = stim_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_fa_bist.sv
// Scoreboard bench for fa_bist: three instances cover the settle/pass
// parameter corners, each driving a behavioural adder with injectable faults.
`timescale 1ns/1ps
module tb_fa_bist;
    import fa_pkg::*;

    typedef struct {
        int         id;
        int         lat;
        logic       pass;
        logic [3:0] err;
        logic       fv;
        logic [2:0] fvec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [1:0] fmode [3];
    wire  [2:0] a_w, b_w, cin_w, busy_w, done_w, pass_w, fv_w;
    wire  [2:0] sum_w, cout_w;
    wire  [3:0] err_w [3];
    wire  [2:0] fvec_w [3];

    exp_t       sb_q [$];
    exp_t       mon_e;
    int         cyc = 0;
    int         start_edge [3];
    int         total = 0;
    int         bad = 0;
    logic [2:0] done_prev = 3'b000;
    logic [2:0] last_abc0 = 3'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adders: mode 1 = sum stuck-at-0, mode 2 = cout inverted.
    for (genvar g = 0; g < 3; g++) begin : g_adder
        assign sum_w[g]  = fa_sum(a_w[g], b_w[g], cin_w[g]) & (fmode[g] != 2'd1);
        assign cout_w[g] = fa_cout(a_w[g], b_w[g], cin_w[g]) ^ (fmode[g] == 2'd2);
    end

    fa_bist #(.SETTLE_CYCLES(2), .PASSES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_w[0]), .b(b_w[0]), .cin(cin_w[0]),
        .dut_cout(cout_w[0]), .dut_sum(sum_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_valid(fv_w[0]), .fail_vec(fvec_w[0])
    );

    fa_bist #(.SETTLE_CYCLES(2), .PASSES(2)) u_dut_p2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_w[1]), .b(b_w[1]), .cin(cin_w[1]),
        .dut_cout(cout_w[1]), .dut_sum(sum_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_valid(fv_w[1]), .fail_vec(fvec_w[1])
    );

    fa_bist #(.SETTLE_CYCLES(0), .PASSES(1)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_w[2]), .b(b_w[2]), .cin(cin_w[2]),
        .dut_cout(cout_w[2]), .dut_sum(sum_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_valid(fv_w[2]), .fail_vec(fvec_w[2])
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int outs(input int i);
        return int'({a_w[i], b_w[i], cin_w[i], busy_w[i], done_w[i], pass_w[i],
                     fv_w[i], err_w[i], fvec_w[i]});
    endfunction

    task automatic expect_run(input int id, input int lat, input logic p,
                              input logic [3:0] err, input logic fv, input logic [2:0] fvec);
        exp_t e;
        e.id = id; e.lat = lat; e.pass = p; e.err = err; e.fv = fv; e.fvec = fvec;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start(input int id);
        @(posedge clk);
        #1 start_v[id] = 1'b1;
        @(posedge clk);
        #1 start_edge[id] = cyc;
        start_v[id] = 1'b0;
        chk("busy_after_start", int'(busy_w[id]), 1);
        chk("done_cleared", int'(done_w[id]), 0);
    endtask

    task automatic wait_done(input int id, input int budget);
        int n = 0;
        while (!done_w[id] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_w[id]) chk("done_timeout", 0, 1);
    endtask

    // Scoreboard monitor: each rising done pops and checks one expected result.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_w[i] && !done_prev[i]) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", i, -1);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("done_id", i, mon_e.id);
                    chk("latency", cyc - start_edge[i], mon_e.lat);
                    chk("pass", int'(pass_w[i]), int'(mon_e.pass));
                    chk("err_count", int'(err_w[i]), int'(mon_e.err));
                    chk("fail_valid", int'(fv_w[i]), int'(mon_e.fv));
                    chk("fail_vec", int'(fvec_w[i]), int'(mon_e.fvec));
                end
            end
        end
        done_prev <= done_w;
    end

    // Stimulus order on the main instance must step 000,001,...,111 while busy.
    always @(negedge clk) begin
        logic [2:0] cur;
        logic [2:0] nxt;
        cur = {a_w[0], b_w[0], cin_w[0]};
        nxt = last_abc0 + 3'd1;
        if (busy_w[0] && cur != last_abc0) chk("abc_order", int'(cur), int'(nxt));
        last_abc0 <= cur;
    end

    initial begin
        rst_n   = 1'b0;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) fmode[i] = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("reset_outputs", outs(i), 0);
        rst_n = 1'b1;

        // Correct adder, settle 2, one pass.
        expect_run(0, 33, 1'b1, 4'd0, 1'b0, 3'd0);
        pulse_start(0);
        wait_done(0, 100);

        // Sum stuck-at-0: vectors 001,010,100,111 fail.
        fmode[0] = 2'd1;
        expect_run(0, 33, 1'b0, 4'd4, 1'b1, 3'b001);
        pulse_start(0);
        wait_done(0, 100);

        // Cout inverted over two passes: 16 mismatches saturate at 15.
        fmode[1] = 2'd2;
        expect_run(1, 65, 1'b0, 4'd15, 1'b1, 3'b000);
        pulse_start(1);
        wait_done(1, 200);

        // Start pulsed mid-run is ignored.
        fmode[0] = 2'd0;
        expect_run(0, 33, 1'b1, 4'd0, 1'b0, 3'd0);
        pulse_start(0);
        repeat (8) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        wait_done(0, 100);

        // Asynchronous reset mid-run, then a fresh clean run.
        pulse_start(0);
        repeat (13) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("mid_run_reset", outs(0), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_run(0, 33, 1'b1, 4'd0, 1'b0, 3'd0);
        pulse_start(0);
        wait_done(0, 100);

        // Zero settle window, then back-to-back starts from DONE.
        expect_run(2, 17, 1'b1, 4'd0, 1'b0, 3'd0);
        pulse_start(2);
        wait_done(2, 60);
        fmode[2] = 2'd1;
        expect_run(2, 17, 1'b0, 4'd4, 1'b1, 3'b001);
        pulse_start(2);
        wait_done(2, 60);
        fmode[2] = 2'd0;
        expect_run(2, 17, 1'b1, 4'd0, 1'b0, 3'd0);
        pulse_start(2);
        wait_done(2, 60);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
